// File: rtl/prf_wr_arbiter.sv
// PRF write-port arbiter: steers writeback requests to their bank, picks one
// winner per bank with a per-bank round-robin pointer, and registers the bank write.
module prf_wr_arbiter #(
  parameter int PR_COUNT       = 128,
  parameter int PRF_BANK_COUNT = 4,
  parameter int PRF_WR_COUNT   = 7,
  parameter int XLEN           = 32,
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int LOG_WR             = $clog2(PRF_WR_COUNT),
  localparam int UPPER_W            = LOG_PR_COUNT - LOG_PRF_BANK_COUNT
) (
  input  logic                                           CLK,
  input  logic                                           nRST,
  input  logic [PRF_WR_COUNT-1:0]                        wr_req_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]      wr_req_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]              wr_req_data_by_wr,
  output logic [PRF_WR_COUNT-1:0]                        wr_req_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                      bank_wr_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]         bank_wr_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]            bank_wr_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    wb_PR_by_bank
);

  localparam logic [LOG_WR:0] WR_LIM = (LOG_WR+1)'(PRF_WR_COUNT);

  logic [PRF_BANK_COUNT-1:0][LOG_WR-1:0]       rr_ptr_r;
  logic [PRF_BANK_COUNT-1:0]                   grant_s;
  logic [PRF_BANK_COUNT-1:0][LOG_WR-1:0]       winner_s;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] win_pr_s;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         win_data_s;
  logic [PRF_WR_COUNT-1:0]                     ready_s;

  logic [PRF_BANK_COUNT-1:0]                   bank_valid_r;
  logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]      bank_upper_r;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         bank_data_r;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] wb_pr_r;

  // Requestor index arithmetic wraps at PRF_WR_COUNT, which need not be a power of 2.
  function automatic logic [LOG_WR-1:0] wrap_add(input logic [LOG_WR-1:0] base,
                                                 input logic [LOG_WR-1:0] off);
    logic [LOG_WR:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= WR_LIM) ? LOG_WR'(sum - WR_LIM) : sum[LOG_WR-1:0];
  endfunction

  // Per-bank round-robin scan starting at rr_ptr; first matching requestor wins.
  always_comb begin
    logic [LOG_WR-1:0] idx;
    logic              hit;
    idx        = '0;
    hit        = 1'b0;
    ready_s    = '0;
    grant_s    = '0;
    winner_s   = '0;
    win_pr_s   = '0;
    win_data_s = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        idx = wrap_add(rr_ptr_r[b], LOG_WR'(k));
        hit = wr_req_valid_by_wr[idx] && !grant_s[b] &&
              (wr_req_PR_by_wr[idx][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
        winner_s[b] = hit ? idx : winner_s[b];
        grant_s[b]  = grant_s[b] | hit;
      end
      ready_s       = ready_s | (PRF_WR_COUNT'(grant_s[b]) << winner_s[b]);
      win_pr_s[b]   = wr_req_PR_by_wr[winner_s[b]];
      win_data_s[b] = wr_req_data_by_wr[winner_s[b]];
    end
  end

  // Round-robin pointers advance past each bank's winner; idle banks hold.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_r <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (grant_s[b]) begin
          rr_ptr_r[b] <= wrap_add(winner_s[b], LOG_WR'(1));
        end else begin
          rr_ptr_r[b] <= rr_ptr_r[b];
        end
      end
    end
  end

  // Registered bank writes; payload holds when a bank is idle so wb_PR stays stable.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_valid_r <= '0;
      bank_upper_r <= '0;
      bank_data_r  <= '0;
      wb_pr_r      <= '0;
    end else begin
      bank_valid_r <= grant_s;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (grant_s[b]) begin
          bank_upper_r[b] <= win_pr_s[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          bank_data_r[b]  <= win_data_s[b];
          wb_pr_r[b]      <= win_pr_s[b];
        end else begin
          bank_upper_r[b] <= bank_upper_r[b];
          bank_data_r[b]  <= bank_data_r[b];
          wb_pr_r[b]      <= wb_pr_r[b];
        end
      end
    end
  end

  assign wr_req_ready_by_wr       = ready_s;
  assign bank_wr_valid_by_bank    = bank_valid_r;
  assign bank_wr_upper_PR_by_bank = bank_upper_r;
  assign bank_wr_data_by_bank     = bank_data_r;
  assign wb_PR_by_bank            = wb_pr_r;

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Directed-vector bench for prf_wr_arbiter with hand-computed expectations.
module tb_prf_wr_arbiter;

  logic                 CLK;
  logic                 nRST;
  logic [6:0]           valid;
  logic [6:0][6:0]      pr;
  logic [6:0][31:0]     data;
  logic [6:0]           ready;
  logic [3:0]           bvalid;
  logic [3:0][4:0]      bupper;
  logic [3:0][31:0]     bdata;
  logic [3:0][6:0]      wbpr;

  int n_vec = 0;
  int n_err = 0;

  prf_wr_arbiter dut (
    .CLK                      (CLK),
    .nRST                     (nRST),
    .wr_req_valid_by_wr       (valid),
    .wr_req_PR_by_wr          (pr),
    .wr_req_data_by_wr        (data),
    .wr_req_ready_by_wr       (ready),
    .bank_wr_valid_by_bank    (bvalid),
    .bank_wr_upper_PR_by_bank (bupper),
    .bank_wr_data_by_bank     (bdata),
    .wb_PR_by_bank            (wbpr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [6:0] p, input logic [31:0] d);
    valid[i] = 1'b1;
    pr[i]    = p;
    data[i]  = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST  = 1'b0;
    valid = '0;
    pr    = '0;
    data  = '0;
    repeat (3) @(posedge CLK);
    #3 nRST = 1'b1;
    step();

    // Reset then idle
    chk("rst_bvalid", 64'(bvalid), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_wbpr", 64'(wbpr), 64'h0);
    chk("rst_bdata", 64'(bdata), 64'h0);

    // No conflict across four banks
    req(0, 7'd5, 32'hAAAA0000);
    req(1, 7'd6, 32'h1);
    req(2, 7'd7, 32'h2);
    req(3, 7'd8, 32'h3);
    #1 chk("nc_ready", 64'(ready), 64'h0F);
    step();
    valid = '0;
    #1 chk("nc_ready_after", 64'(ready), 64'h0);
    chk("nc_bvalid", 64'(bvalid), 64'hF);
    chk("nc_b1_upper", 64'(bupper[1]), 64'd1);
    chk("nc_b1_data", 64'(bdata[1]), 64'hAAAA0000);
    chk("nc_b1_wb", 64'(wbpr[1]), 64'd5);
    chk("nc_b2_wb", 64'(wbpr[2]), 64'd6);
    chk("nc_b2_data", 64'(bdata[2]), 64'h1);
    chk("nc_b3_wb", 64'(wbpr[3]), 64'd7);
    chk("nc_b3_upper", 64'(bupper[3]), 64'd1);
    chk("nc_b0_upper", 64'(bupper[0]), 64'd2);
    chk("nc_b0_wb", 64'(wbpr[0]), 64'd8);

    // Mid-cycle async reset drops the in-flight writes at once
    nRST = 1'b0;
    #1 chk("async_rst_bvalid", 64'(bvalid), 64'h0);
    chk("async_rst_wbpr", 64'(wbpr), 64'h0);
    req(3, 7'd1, 32'h0);
    req(0, 7'd1, 32'h0);
    #1 chk("rst_ready_ptr0", 64'(ready), 64'h01);
    valid = '0;
    step();
    #2 nRST = 1'b1;
    step();

    // Same-bank contention: req0, req3, req6 -> PR 12
    req(0, 7'd12, 32'h100);
    req(3, 7'd12, 32'h103);
    req(6, 7'd12, 32'h106);
    #1 chk("ct_ready0", 64'(ready), 64'h01);
    step();
    valid[0] = 1'b0;
    #1 chk("ct_ready1", 64'(ready), 64'h08);
    chk("ct_bv1", 64'(bvalid[0]), 64'd1);
    chk("ct_data1", 64'(bdata[0]), 64'h100);
    chk("ct_upper1", 64'(bupper[0]), 64'd3);
    chk("ct_wb1", 64'(wbpr[0]), 64'd12);
    step();
    valid[3] = 1'b0;
    #1 chk("ct_ready2", 64'(ready), 64'h40);
    chk("ct_bv2", 64'(bvalid[0]), 64'd1);
    chk("ct_data2", 64'(bdata[0]), 64'h103);
    step();
    valid[6] = 1'b0;
    #1 chk("ct_ready3", 64'(ready), 64'h0);
    chk("ct_bv3", 64'(bvalid[0]), 64'd1);
    chk("ct_data3", 64'(bdata[0]), 64'h106);
    step();
    chk("ct_bv4", 64'(bvalid[0]), 64'd0);
    chk("ct_hold4", 64'(bdata[0]), 64'h106);
    req(0, 7'd0, 32'h0);
    req(6, 7'd0, 32'h0);
    #1 chk("ct_ptr_wrapped", 64'(ready), 64'h01);
    valid = '0;

    // Round-robin wrap on bank 1: move rr_ptr[1] to 6 first
    step();
    req(5, 7'd1, 32'h55);
    #1 chk("rr_setup_ready", 64'(ready), 64'h20);
    step();
    valid = '0;
    req(0, 7'd1, 32'hA0);
    req(5, 7'd1, 32'hA5);
    #1 chk("rr_wrap_ready", 64'(ready), 64'h01);
    step();
    valid[0] = 1'b0;
    #1 chk("rr_second_ready", 64'(ready), 64'h20);
    chk("rr_b1_data0", 64'(bdata[1]), 64'hA0);
    chk("rr_b1_wb0", 64'(wbpr[1]), 64'd1);
    chk("rr_b1_upper0", 64'(bupper[1]), 64'd0);
    step();
    valid = '0;
    #1 chk("rr_b1_data5", 64'(bdata[1]), 64'hA5);
    req(0, 7'd1, 32'h0);
    req(6, 7'd1, 32'h0);
    #1 chk("rr_ptr6", 64'(ready), 64'h40);
    valid = '0;
    step();

    // Starvation: all seven requestors continuously to bank 3
    for (int i = 0; i < 7; i++) req(i, 7'(i * 4 + 3), 32'h300 + 32'(i));
    for (int c = 0; c < 14; c++) begin
      #1 chk($sformatf("sv_ready_%0d", c), 64'(ready), 64'(7'b1 << (c % 7)));
      step();
      chk($sformatf("sv_bv_%0d", c), 64'(bvalid[3]), 64'd1);
      chk($sformatf("sv_data_%0d", c), 64'(bdata[3]), 64'(32'h300 + 32'(c % 7)));
      chk($sformatf("sv_wb_%0d", c), 64'(wbpr[3]), 64'((c % 7) * 4 + 3));
    end
    valid = '0;
    step();
    chk("sv_bv_idle", 64'(bvalid[3]), 64'd0);

    // Hold on idle: single grant to bank 2 then nothing
    req(4, 7'd2, 32'h1234);
    #1 chk("hold_ready", 64'(ready), 64'h10);
    step();
    valid = '0;
    #1 chk("hold_bv1", 64'(bvalid[2]), 64'd1);
    chk("hold_data1", 64'(bdata[2]), 64'h1234);
    step();
    chk("hold_bv0", 64'(bvalid[2]), 64'd0);
    chk("hold_data", 64'(bdata[2]), 64'h1234);
    chk("hold_wb", 64'(wbpr[2]), 64'd2);
    req(4, 7'd6, 32'h0);
    req(5, 7'd6, 32'h0);
    #1 chk("hold_ptr5", 64'(ready), 64'h20);
    valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
